// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and encodings for the multicycle RV32I-subset control path
package riscv_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } statetype_t;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: ALUOp/funct to alu_control decoder
// Ports: i_alu_op (ALUOp), i_funct3, i_op5 (op[5]), i_funct7b5, o_alu_control
module mc_aludec
    import riscv_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);
    // op[5] separates R-type sub from I-type addi, whose bit 30 is immediate data
    assign o_alu_control = i_alu_op == ALUOP_SUB     ? ALU_SUB :
                           i_alu_op != ALUOP_FUNCT   ? ALU_ADD :
                           i_funct3 == 3'b000        ? (i_op5 & i_funct7b5 ? ALU_SUB : ALU_ADD) :
                           i_funct3 == 3'b010        ? ALU_SLT :
                           i_funct3 == 3'b110        ? ALU_OR  :
                           i_funct3 == 3'b111        ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencing FSM for the shared-memory multicycle datapath
// Inputs: clk, reset (async, active-low), op/funct3/funct7b5 from IR, zero flag, mem_ready handshake
// Outputs: datapath enables/selects, imm_src, alu_control, retire pulse, illegal (TRAP)
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal
);
    statetype_t r_state, w_next;
    logic [1:0] w_alu_op;

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;

    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        w_alu_op   = ALUOP_ADD;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                w_next    = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                            op == OP_R   ? S_EXECR :
                            op == OP_I   ? S_EXECI :
                            op == OP_BEQ ? S_BEQ   :
                            op == OP_JAL ? S_JAL   : S_TRAP;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                w_next    = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                w_alu_op  = ALUOP_SUB;
                pc_write  = zero;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                w_next    = S_FETCH;
            end
            S_TRAP:  illegal = 1'b1;
            default: w_next = S_FETCH;
        endcase
        // state is already FETCH during reset; only the mem_ready-driven enables need masking
        if (!reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    assign imm_src = op == OP_SW  ? 2'b01 :
                     op == OP_BEQ ? 2'b10 :
                     op == OP_JAL ? 2'b11 : 2'b00;

    mc_aludec u_aludec (
        .i_alu_op     (w_alu_op),
        .i_funct3     (funct3),
        .i_op5        (op[5]),
        .i_funct7b5   (funct7b5),
        .o_alu_control(alu_control)
    );
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl; per-cycle expected output vectors
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    int         n_pass = 0;
    int         n_chk = 0;
    logic [17:0] exp_q[$];
    string       tag_q[$];

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .reg_write(reg_write), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // vector: pcw adr mw irw res[2] a[2] b[2] imm[2] alu[3] rw ret ill
    function automatic logic [1:0] imm_of(input logic [6:0] o);
        return o == 7'b0100011 ? 2'b01 : o == 7'b1100011 ? 2'b10 : o == 7'b1101111 ? 2'b11 : 2'b00;
    endfunction
    function automatic logic [17:0] ev(input logic pcw, adr, mw, irw, input logic [1:0] res, sa, sb,
                                       input logic [2:0] alu, input logic rw, ret, ill);
        return {pcw, adr, mw, irw, res, sa, sb, imm_of(op), alu, rw, ret, ill};
    endfunction
    function automatic logic [17:0] e_fetch(input logic mr);  return ev(mr,0,0,mr,2'b10,2'b00,2'b10,3'b000,0,0,0); endfunction
    function automatic logic [17:0] e_dec();                   return ev(0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0,0); endfunction
    function automatic logic [17:0] e_execr(input logic [2:0] a); return ev(0,0,0,0,2'b00,2'b10,2'b00,a,0,0,0); endfunction
    function automatic logic [17:0] e_execi(input logic [2:0] a); return ev(0,0,0,0,2'b00,2'b10,2'b01,a,0,0,0); endfunction
    function automatic logic [17:0] e_aluwb();                 return ev(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,1,0); endfunction
    function automatic logic [17:0] e_memadr();                return ev(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0); endfunction
    function automatic logic [17:0] e_memrd();                 return ev(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0); endfunction
    function automatic logic [17:0] e_memwb();                 return ev(0,0,0,0,2'b01,2'b00,2'b00,3'b000,1,1,0); endfunction
    function automatic logic [17:0] e_memwr(input logic mr);   return ev(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0,mr,0); endfunction
    function automatic logic [17:0] e_beq(input logic z);      return ev(z,0,0,0,2'b00,2'b10,2'b00,3'b001,0,1,0); endfunction
    function automatic logic [17:0] e_jal();                   return ev(1,0,0,0,2'b00,2'b01,2'b10,3'b000,1,1,0); endfunction
    function automatic logic [17:0] e_trap();                  return ev(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,1); endfunction

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b want %b (pcw adr mw irw res a b imm alu rw ret ill)", tag, got, want);
    endtask

    always @(negedge clk)
        if (exp_q.size() > 0)
            check(tag_q.pop_front(),
                  {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                   imm_src, alu_control, reg_write, retire, illegal},
                  exp_q.pop_front());

    task automatic cyc(input string tag, input logic mr, input logic [17:0] e);
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    logic [2:0] f3_tab[6]  = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001};
    logic       f7_tab[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] r_alu[6]   = '{3'b000, 3'b001, 3'b101, 3'b011, 3'b010, 3'b000};
    logic [2:0] i_alu[6]   = '{3'b000, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000};

    initial begin
        reset = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        set_ins(7'b0110011, 3'b000, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cyc("reset", 1, e_fetch(0));
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_ins(7'b0110011, f3_tab[i], f7_tab[i]);
            cyc("r_fetch", 1, e_fetch(1)); cyc("r_dec", 1, e_dec());
            cyc("r_exec", 1, e_execr(r_alu[i])); cyc("r_wb", 1, e_aluwb());
        end
        for (int i = 0; i < 6; i++) begin
            set_ins(7'b0010011, f3_tab[i], f7_tab[i]);
            cyc("i_fetch", 1, e_fetch(1)); cyc("i_dec", 1, e_dec());
            cyc("i_exec", 1, e_execi(i_alu[i])); cyc("i_wb", 1, e_aluwb());
        end
        set_ins(7'b0000011, 3'b010, 1'b0);
        cyc("lw_fwait", 0, e_fetch(0)); cyc("lw_fwait", 0, e_fetch(0));
        cyc("lw_fetch", 1, e_fetch(1)); cyc("lw_dec", 1, e_dec()); cyc("lw_adr", 1, e_memadr());
        cyc("lw_rd_wait", 0, e_memrd()); cyc("lw_rd_wait", 0, e_memrd()); cyc("lw_rd", 1, e_memrd());
        cyc("lw_wb", 1, e_memwb());
        set_ins(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch", 1, e_fetch(1)); cyc("sw_dec", 1, e_dec()); cyc("sw_adr", 1, e_memadr());
        for (int i = 0; i < 3; i++) cyc("sw_wr_wait", 0, e_memwr(0));
        cyc("sw_wr", 1, e_memwr(1));
        set_ins(7'b1100011, 3'b000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            zero = ~i[0];
            cyc("beq_fetch", 1, e_fetch(1)); cyc("beq_dec", 1, e_dec()); cyc("beq", 1, e_beq(~i[0]));
        end
        set_ins(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch", 1, e_fetch(1)); cyc("jal_dec", 1, e_dec()); cyc("jal", 1, e_jal());
        set_ins(7'b0000011, 3'b010, 1'b0);
        cyc("abort_fetch", 1, e_fetch(1)); cyc("abort_dec", 1, e_dec()); cyc("abort_adr", 1, e_memadr());
        cyc("abort_rd", 0, e_memrd());
        reset = 1'b0;
        cyc("abort_reset", 1, e_fetch(0));
        reset = 1'b1;
        cyc("rerun_fetch", 1, e_fetch(1)); cyc("rerun_dec", 1, e_dec()); cyc("rerun_adr", 1, e_memadr());
        cyc("rerun_rd", 1, e_memrd()); cyc("rerun_wb", 1, e_memwb());
        set_ins(7'b1111111, 3'b000, 1'b1);
        zero = 1'b1;
        cyc("ill_fetch", 1, e_fetch(1)); cyc("ill_dec", 1, e_dec());
        for (int i = 0; i < 10; i++) cyc("trap", 1, e_trap());
        reset = 1'b0;
        cyc("trap_reset", 1, e_fetch(0));
        reset = 1'b1;
        set_ins(7'b0110011, 3'b000, 1'b0);
        cyc("post_trap_fetch", 1, e_fetch(1)); cyc("post_trap_dec", 1, e_dec());
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multicycle RV32I-subset core: a Moore FSM that drives the shared-memory multicycle datapath through Fetch/Decode/Execute/Writeback for lw, sw, R-type, I-type ALU, beq and jal. It replaces the single-cycle control path. Instruction and data share one memory port, and every memory access waits on a ready handshake. It also reports instruction retirement and illegal opcodes.

## Interface
No parameters.
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low; 0 = in reset
- op  in  7  instruction [6:0], from the IR
- funct3  in  3  instruction [14:12]
- funct7b5  in  1  instruction [30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR/OldPC register enable
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register
- alu_src_b  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- reg_write  out  1  register-file write enable
- retire  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  high while in TRAP

## Operation
States, with the Moore outputs that are asserted (all others are 0 and select 00). ALUOp is 00 = add, 01 = sub, 10 = funct.
- FETCH
  - outputs: adr_src=0, src_a=00, src_b=10, ALUOp=00, result_src=10
  - ir_write = pc_write = mem_ready
  - next state: DECODE if mem_ready, else stay in FETCH
- DECODE
  - outputs: src_a=01, src_b=01, ALUOp=00 (computes the branch/jal target into ALUOut)
  - next state by op:
    - 0000011 and 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → TRAP
- MEMADR
  - outputs: src_a=10, src_b=01, ALUOp=00
  - next state: MEMREAD if op[5]=0, MEMWRITE if op[5]=1
- MEMREAD
  - outputs: adr_src=1
  - next state: MEMWB on mem_ready, else stay
- MEMWB
  - outputs: result_src=01, reg_write, retire
  - next state: FETCH
- MEMWRITE
  - outputs: adr_src=1, mem_write held until mem_ready
  - on mem_ready: retire, next state FETCH; else stay
- EXECR
  - outputs: src_a=10, src_b=00, ALUOp=10
  - next state: ALUWB
- EXECI
  - outputs: src_a=10, src_b=01, ALUOp=10
  - next state: ALUWB
- ALUWB
  - outputs: result_src=00, reg_write, retire
  - next state: FETCH
- BEQ
  - outputs: src_a=10, src_b=00, ALUOp=01, result_src=00, pc_write = zero, retire
  - next state: FETCH
- JAL
  - outputs: src_a=01, src_b=10, ALUOp=00, result_src=00, pc_write, reg_write, retire
  - next state: FETCH
- TRAP
  - outputs: illegal
  - no write enables asserted
  - stays in TRAP until reset

Decoders (combinational):
- imm_src from op: lw/I-type → 00, sw → 01, beq → 10, jal → 11, any other op → 00.
- ALU decoder, ALUOp=10, by funct3:
  - 000: sub if op[5] & funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - any other funct3: add

## Timing
- State register:
  - updates on the rising edge of clk
  - on reset=0, the state goes to FETCH immediately (asynchronously)
- Outputs: combinational from state, op, funct3, funct7b5, zero and mem_ready. No output registers.
- While reset=0, pc_write, ir_write, mem_write, reg_write and retire are forced to 0.
- Other outputs while reset=0 take their FETCH values: adr_src=0, src_a=00, src_b=10, result_src=10, alu_control=000, illegal=0.
- Cycles per instruction with zero wait states:
  - lw: 5
  - sw: 4
  - R-type and I-type: 4
  - beq: 3
  - jal: 3
  - each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_write and adr_src stay stable for the whole of a MEMWRITE wait.
- Reset asserted mid-instruction aborts it: no retire, and no write enable is asserted after reset falls.
- retire is exactly one cycle per instruction. It is never asserted in TRAP.

## Structure
- Shared package riscv_pkg holds:
  - the state enum (statetype_t)
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUOp and alu_control encodings
  - the result_src, alu_src_a and alu_src_b select encodings
- One sub-module, mc_aludec: the combinational ALUOp/funct → alu_control decoder.
- The FSM and the imm_src decoder live in multicycle_ctrl.

## Test plan
- Reset: hold reset=0 for 3 cycles with mem_ready=1 → all write enables 0. After release, FETCH asserts pc_write=ir_write=1 in the first cycle.
- R-type add (op=0110011, funct3=000, funct7b5=0), mem_ready=1 → state sequence FETCH, DECODE, EXECR, ALUWB; alu_control=000 in EXECR; reg_write and retire in cycle 4.
  - Repeat with funct7b5=1 → alu_control=001.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; result_src=01 and reg_write in MEMWB.
- sw with mem_ready=0 for 3 cycles → mem_write=1 and adr_src=1 held for 4 cycles; retire once in the final cycle.
- beq → pc_write follows zero in BEQ (zero=1 → 1, zero=0 → 0). jal → pc_write=reg_write=1 with result_src=00.
- Illegal op 1111111 → TRAP, illegal=1 and no writes for 10 cycles. Then reset=0 → FETCH.
